encoder4x2_sync: RTL and testbench
==================================

// Module: encoder4x2_sync
// PURPOSE
//  Registered 4-to-2 encoder: inverse of the lab 2x4 decoder. Samples a 4-bit one-hot (p=0) or
//  one-cold (p=1) code, requires it stable for STABLE_CYCLES samples, then presents the 2-bit index
//  on a valid/ready handshake. Flags invalid codes. Sits between switch/decoder outputs and LED/consumer logic.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before acceptance; legal range >= 2
//  ERRCNT_W       8  width of the invalid-code counter (ENCODER_ERR_COUNT_EN only)
// PORTS
//  clk        in   1         system clock; single clock domain, all state on rising edge
//  reset      in   1         synchronous, active-high reset
//  enable     in   1         active-high DISABLE (decoder convention): 1 = block idle
//  p          in   1         polarity: 0 = one-hot input, 1 = one-cold input
//  y          in   [0:3]     code input, y[0] leftmost bit
//  a_out      out  2         encoded index
//  out_valid  out  1         a_out holds an accepted code
//  out_ready  in   1         consumer accepts a_out when out_valid && out_ready at a rising edge
//  code_err   out  1         one-cycle pulse: stable but invalid code detected
//  err_count  out  ERRCNT_W  saturating invalid-code count (ENCODER_ERR_COUNT_EN only)
// BEHAVIOUR
//  - Normalise v = p ? ~y : y. Map: v=1000->00, 0100->01, 0010->10, 0001->11. Any other v is invalid
//    (0000, multi-bit). Identical to decoder truth table read backwards, incl. p=1 (0111->00 ... 1110->11).
//  - Reset: state IDLE, a_out=2'b00, out_valid=0, code_err=0, err_count=0, stable cnt=0, v_prev=0.
//  - FSM states IDLE, TRACK, PRESENT, WAIT_CHG:
//    IDLE: enable=0 -> TRACK; load v_prev=v, cnt=1.
//    TRACK: v==v_prev -> cnt++; else v_prev=v, cnt=1. On the edge cnt would reach STABLE_CYCLES:
//      valid v -> a_out=index, out_valid=1, PRESENT; invalid v -> code_err=1 for one cycle, WAIT_CHG.
//    PRESENT: hold a_out/out_valid stable until out_valid && out_ready -> out_valid=0, WAIT_CHG.
//      Input changes while PRESENT are ignored.
//    WAIT_CHG: stay until v != v_prev; then v_prev=v, cnt=1, TRACK. A held code yields exactly one output.
//  - Latency: enable low from reset with y fixed -> out_valid high after rising edge STABLE_CYCLES.
//  - enable=1 in any state: next edge -> IDLE, out_valid=0, code_err=0, cnt=0; a_out holds last value.
//    Unaccepted pending output is discarded. If out_valid&&out_ready in the same cycle enable rises,
//    the transfer counts as completed.
//  - p toggling mid-TRACK changes v -> counter restarts; no special case.
//  - reset overrides enable and all handshakes in the same edge.
//  - a_out changes only on the TRACK->PRESENT edge; never while out_valid=1.
// CONFIGURATION
//  ENCODER_ERR_COUNT_EN defined: err_count port present; increments on each code_err pulse,
//    saturates at all-ones, cleared only by reset.
//  Undefined: err_count port and counter absent; code_err unchanged.
// STRUCTURE
//  encoder_pkg: typedef enum state_t {IDLE,TRACK,PRESENT,WAIT_CHG}; code constants
//    CODE_0..CODE_3 (4'b1000..4'b0001); function onehot_to_idx returning {valid, idx}.
//  Sub-module code_stabilizer: owns v_prev and cnt, outputs stable pulse and changed flag;
//    top holds FSM, output registers, err counter.
// TESTING
//  1 reset, enable=0, p=0, y=0100 held -> out_valid=1, a_out=01 after edge 4; stays until out_ready.
//  2 p=1, y=1101 held, out_ready=1 -> a_out=10, one transfer only; no second out_valid while held.
//  3 y=1100 held -> code_err pulse once at edge 4, out_valid stays 0; err_count=1 (if enabled);
//    300 invalid events with ERRCNT_W=8 -> err_count=255.
//  4 y toggles 1000/0100 every 2 cycles -> out_valid never asserts; then y=0001 held -> a_out=11.
//  5 out_valid=1, out_ready=0, raise enable -> out_valid=0 next edge, state IDLE, a_out held;
//    drop enable with y=0010 -> new output a_out=10 after STABLE_CYCLES edges.
//  6 reset asserted while PRESENT -> all outputs to reset values on that edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types, code constants and decode helper for the registered 4-to-2 encoder.
// Optional feature macro used by this block: ENCODER_ERR_COUNT_EN (invalid-code counter).
package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    PRESENT,
    WAIT_CHG
  } state_t;

  // Normalised (one-hot) codes, leftmost bit first; index is the position of the set bit.
  localparam logic [0:3] CODE_0 = 4'b1000;
  localparam logic [0:3] CODE_1 = 4'b0100;
  localparam logic [0:3] CODE_2 = 4'b0010;
  localparam logic [0:3] CODE_3 = 4'b0001;

  // Returns {valid, idx}; anything that is not exactly one set bit is invalid.
  function automatic logic [2:0] onehot_to_idx(input logic [0:3] v);
    logic [2:0] res;
    case (v)
      CODE_0:  res = {1'b1, 2'd0};
      CODE_1:  res = {1'b1, 2'd1};
      CODE_2:  res = {1'b1, 2'd2};
      CODE_3:  res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/encoder4x2_sync_if.sv
// Code input / handshake bundle for encoder4x2_sync.
// err_count and its width parameter exist only when ENCODER_ERR_COUNT_EN is defined.
interface encoder4x2_sync_if
`ifdef ENCODER_ERR_COUNT_EN
  #(parameter int unsigned ERRCNT_W = 8)
`endif
  ;

  logic       enable;     // active-high disable
  logic       p;          // 0 = one-hot, 1 = one-cold
  logic [0:3] y;          // y[0] is the leftmost bit
  logic [1:0] a_out;
  logic       out_valid;
  logic       out_ready;
  logic       code_err;
`ifdef ENCODER_ERR_COUNT_EN
  logic [ERRCNT_W-1:0] err_count;
`endif

  // Encoder side
  modport master (
    input  enable,
    input  p,
    input  y,
    input  out_ready,
    output a_out,
    output out_valid,
`ifdef ENCODER_ERR_COUNT_EN
    output err_count,
`endif
    output code_err
  );

  // Code source / consumer side
  modport slave (
    output enable,
    output p,
    output y,
    output out_ready,
    input  a_out,
    input  out_valid,
`ifdef ENCODER_ERR_COUNT_EN
    input  err_count,
`endif
    input  code_err
  );

endinterface

// File: rtl/code_stabilizer.sv
// Tracks the previous normalised code and how many consecutive identical samples were seen.
// stable_o flags that one more identical sample completes the required run.
module code_stabilizer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [0:3] v_i,
  input  logic       load_i,    // restart run from the current sample
  input  logic       count_i,   // extend run, or restart if the sample differs
  input  logic       clear_i,   // zero the run length
  output logic       stable_o,
  output logic       changed_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  logic [0:3]      v_prev_q, v_prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign changed_o = (v_i != v_prev_q);
  assign stable_o  = !changed_o && (cnt_q == CntW'(STABLE_CYCLES - 1));

  // Next run state; count saturates so a held code never wraps.
  always_comb begin
    v_prev_d = v_prev_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i || (count_i && changed_o)) begin
      v_prev_d = v_i;
      cnt_d    = CntW'(1);
    end else if (count_i && (cnt_q < CntW'(STABLE_CYCLES))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Run state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      v_prev_q <= v_prev_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/encoder4x2_sync.sv
// Registered 4-to-2 encoder: debounces a one-hot/one-cold code, presents its index on a
// valid/ready handshake and pulses code_err for stable invalid codes.
// ENCODER_ERR_COUNT_EN adds a saturating invalid-code counter (err_count).
module encoder4x2_sync
  import encoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
`ifdef ENCODER_ERR_COUNT_EN
  , parameter int unsigned ERRCNT_W = 8
`endif
) (
  input logic                clk,
  input logic                reset,
  encoder4x2_sync_if.master  bus
);

  logic [0:3] v;
  logic [2:0] dec;
  logic       dec_valid;
  logic [1:0] dec_idx;

  state_t     state_q, state_d;
  logic [1:0] a_out_q, a_out_d;
  logic       out_valid_q, out_valid_d;
  logic       code_err_q, code_err_d;

  logic       stb_load, stb_count, stb_clear;
  logic       stable, changed;

  assign v         = bus.p ? ~bus.y : bus.y;
  assign dec       = onehot_to_idx(v);
  assign dec_valid = dec[2];
  assign dec_idx   = dec[1:0];

  code_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk_i    (clk),
    .reset_i  (reset),
    .v_i      (v),
    .load_i   (stb_load),
    .count_i  (stb_count),
    .clear_i  (stb_clear),
    .stable_o (stable),
    .changed_o(changed)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; enable (a disable) forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     state_d = TRACK;
        TRACK:    if (stable) state_d = dec_valid ? PRESENT : WAIT_CHG;
        PRESENT:  if (bus.out_ready) state_d = WAIT_CHG;
        WAIT_CHG: if (changed) state_d = TRACK;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output register next values and stabilizer commands.
  always_comb begin
    a_out_d     = a_out_q;
    out_valid_d = out_valid_q;
    code_err_d  = 1'b0;
    stb_load    = 1'b0;
    stb_count   = 1'b0;
    stb_clear   = 1'b0;
    if (bus.enable) begin
      // Pending output is dropped; a_out keeps its last value.
      out_valid_d = 1'b0;
      stb_clear   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          stb_load = 1'b1;
        end
        TRACK: begin
          stb_count = 1'b1;
          if (stable) begin
            if (dec_valid) begin
              a_out_d     = dec_idx;
              out_valid_d = 1'b1;
            end else begin
              code_err_d = 1'b1;
            end
          end
        end
        PRESENT: begin
          if (bus.out_ready) out_valid_d = 1'b0;
        end
        WAIT_CHG: begin
          stb_load = changed;
        end
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out_q     <= 2'b00;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      a_out_q     <= a_out_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.code_err  = code_err_q;

`ifdef ENCODER_ERR_COUNT_EN
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  // Counts alongside the code_err pulse, saturating at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (code_err_d && (err_count_q != '1)) err_count_d = err_count_q + ERRCNT_W'(1);
  end

  // Error counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_encoder4x2_sync.sv
// Self-checking bench for encoder4x2_sync: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the encoder.
module tb_encoder4x2_sync;

  localparam int unsigned STABLE = 4;
  localparam int unsigned ERRW   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  encoder4x2_sync_if
`ifdef ENCODER_ERR_COUNT_EN
    #(.ERRCNT_W(ERRW))
`endif
    enc_if ();

  encoder4x2_sync #(
    .STABLE_CYCLES(STABLE)
`ifdef ENCODER_ERR_COUNT_EN
    , .ERRCNT_W(ERRW)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (enc_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit         m_active;   // left idle since the last disable/reset
  bit         m_armed;    // a decision may still be made for the current code
  bit         m_pending;  // an accepted index awaits the consumer
  int         m_run;      // consecutive identical samples seen
  logic [0:3] m_last;
  logic [1:0] m_a;
  bit         m_err;
  int         m_errcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic pol, input logic [0:3] code,
                       input logic rdy);
    reset            = rst;
    enc_if.enable    = en;
    enc_if.p         = pol;
    enc_if.y         = code;
    enc_if.out_ready = rdy;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_step();
    logic [0:3] v;
    int         ones;
    int         idx;
    v = enc_if.p ? ~enc_if.y : enc_if.y;
    if (reset) begin
      m_active = 0; m_armed = 0; m_pending = 0; m_run = 0;
      m_last = '0; m_a = 2'b00; m_err = 0; m_errcnt = 0;
    end else if (enc_if.enable) begin
      m_active = 0; m_pending = 0; m_err = 0; m_run = 0;
    end else if (!m_active) begin
      m_active = 1; m_armed = 1; m_last = v; m_run = 1; m_err = 0;
    end else begin
      m_err = 0;
      if (m_pending) begin
        if (enc_if.out_ready) m_pending = 0;
      end else if (!m_armed) begin
        if (v != m_last) begin
          m_last = v; m_run = 1; m_armed = 1;
        end
      end else begin
        if (v == m_last) m_run++;
        else begin
          m_last = v; m_run = 1;
        end
        if (m_run == STABLE) begin
          ones = 0;
          idx  = 0;
          for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
              ones++;
              idx = i;
            end
          end
          m_armed = 0;
          if (ones == 1) begin
            m_a = 2'(idx);
            m_pending = 1;
          end else begin
            m_err = 1;
            if (m_errcnt < (1 << ERRW) - 1) m_errcnt++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(enc_if.out_valid), 32'(m_pending));
    chk("a_out", 32'(enc_if.a_out), 32'(m_a));
    chk("code_err", 32'(enc_if.code_err), 32'(m_err));
`ifdef ENCODER_ERR_COUNT_EN
    chk("err_count", 32'(enc_if.err_count), 32'(m_errcnt));
`endif
  endtask

  // Inputs are changed around the falling edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [0:3] codes [4];
  logic [0:3] code;
  logic       pol;
  logic       rst_r, en_r;
  int         r, len;

  initial begin
    codes[0] = 4'b1000; codes[1] = 4'b0100; codes[2] = 4'b0010; codes[3] = 4'b0001;
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    @(negedge clk);

    // Reset state
    cycle();
    chk("reset_valid", 32'(enc_if.out_valid), 32'd0);
    chk("reset_a", 32'(enc_if.a_out), 32'd0);

    // One-hot 0100 held: index 01 after edge 4, held until out_ready
    drive(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    run(3);
    chk("t1_not_yet", 32'(enc_if.out_valid), 32'd0);
    cycle();
    chk("t1_valid", 32'(enc_if.out_valid), 32'd1);
    chk("t1_a", 32'(enc_if.a_out), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    run(5);
    chk("t1_hold_a", 32'(enc_if.a_out), 32'd1);
    enc_if.out_ready = 1'b1;
    cycle();
    chk("t1_taken", 32'(enc_if.out_valid), 32'd0);
    run(2);

    // One-cold 1101 -> 10, a single transfer while held
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 4'b1101, 1'b1);
    run(4);
    chk("t2_valid", 32'(enc_if.out_valid), 32'd1);
    chk("t2_a", 32'(enc_if.a_out), 32'd2);
    run(10);
    chk("t2_once", 32'(enc_if.out_valid), 32'd0);

    // Invalid 1100: one code_err pulse at edge 4, no output
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 4'b1100, 1'b1);
    run(4);
    chk("t3_err", 32'(enc_if.code_err), 32'd1);
    cycle();
    chk("t3_err_pulse", 32'(enc_if.code_err), 32'd0);
`ifdef ENCODER_ERR_COUNT_EN
    chk("t3_cnt", 32'(enc_if.err_count), 32'd1);
`endif
    run(6);

    // Code toggling every 2 cycles never settles; then 0001 held -> 11
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
      run(2);
      drive(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
      run(2);
    end
    chk("t4_quiet", 32'(enc_if.out_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    run(4);
    chk("t4_valid", 32'(enc_if.out_valid), 32'd1);
    chk("t4_a", 32'(enc_if.a_out), 32'd3);

    // Disable while presenting discards the output, a_out held; re-enable with 0010
    enc_if.enable = 1'b1;
    cycle();
    chk("t5_drop", 32'(enc_if.out_valid), 32'd0);
    chk("t5_a_held", 32'(enc_if.a_out), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    run(4);
    chk("t5_valid", 32'(enc_if.out_valid), 32'd1);
    chk("t5_a", 32'(enc_if.a_out), 32'd2);

    // Reset while presenting
    reset = 1'b1;
    cycle();
    chk("t6_valid", 32'(enc_if.out_valid), 32'd0);
    chk("t6_a", 32'(enc_if.a_out), 32'd0);
    chk("t6_err", 32'(enc_if.code_err), 32'd0);

    // 300 invalid events alternating between two invalid codes
    drive(1'b0, 1'b0, 1'b0, 4'b1100, 1'b0);
    for (int i = 0; i < 300; i++) begin
      enc_if.y = (i % 2 == 0) ? 4'b1100 : 4'b1010;
      run(4);
    end
`ifdef ENCODER_ERR_COUNT_EN
    chk("t3_saturate", 32'(enc_if.err_count), 32'd255);
`endif

    // Random phase
    pol = 1'b0;
    for (int s = 0; s < 350; s++) begin
      r     = $urandom_range(0, 99);
      rst_r = (r < 3);
      en_r  = (r >= 3) && (r < 12);
      if ($urandom_range(0, 9) == 0) pol = ~pol;
      if ($urandom_range(0, 9) < 7) code = codes[$urandom_range(0, 3)] ^ {4{pol}};
      else code = 4'($urandom);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        drive((c == 0) ? rst_r : 1'b0, en_r, pol, code, 1'($urandom_range(0, 1)));
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
